// File: rtl/mbledhesi_sekuencial_if.sv
// Handshake and operand/result bundle between the control unit and the
// sequential adder/subtractor.
interface mbledhesi_sekuencial_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;
  logic             busy;
  logic             done;

  // Control unit side: issues operations, reads results and status.
  modport master (
    output start, sub, a, b, cin,
    input  sum, cout, ovf, zero, neg, busy, done
  );

  // Adder side: accepts operations, drives results and status.
  modport slave (
    input  start, sub, a, b, cin,
    output sum, cout, ovf, zero, neg, busy, done
  );
endinterface

// File: rtl/mbledhesi_sekuencial.sv
// Multi-cycle adder/subtractor: ripples carry through the operands one
// CHUNK-bit slice per clock and reports carry, signed overflow, zero and
// negative flags through a START/BUSY/DONE handshake.
module mbledhesi_sekuencial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  mbledhesi_sekuencial_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  generate
    if ((CHUNK < 1) || (WIDTH < 2) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("mbledhesi_sekuencial: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Operands shift right by one slice per RUN cycle, so the slice being
  // processed is always the low CHUNK bits; the partial result fills from
  // the top so it is aligned once the last slice has been written.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic [CHUNK-1:0] w_sa;
  logic [CHUNK-1:0] w_sb;
  logic [CHUNK:0]   w_slice;
  logic [WIDTH+CHUNK-1:0] w_cat;
  logic [WIDTH-1:0] w_full;
  logic             w_msb_cin;
  logic [WIDTH-1:0] w_b_in;

  assign w_sa    = r_a[CHUNK-1:0];
  assign w_sb    = r_b[CHUNK-1:0];
  assign w_slice = {1'b0, w_sa} + {1'b0, w_sb} + {{CHUNK{1'b0}}, r_carry};
  assign w_cat   = {w_slice[CHUNK-1:0], r_res};
  assign w_full  = w_cat[WIDTH+CHUNK-1:CHUNK];
  // Carry into the slice MSB recovered from that bit's own sum; only
  // meaningful (and only used) while the top slice is being processed.
  assign w_msb_cin = w_sa[CHUNK-1] ^ w_sb[CHUNK-1] ^ w_slice[CHUNK-1];
  assign w_b_in    = bus.sub ? ~bus.b : bus.b;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE waits for START, RUN leaves after the top slice.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath control strobes decoded from the current state.
  always_comb begin
    w_accept = 1'b0;
    w_run    = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept = bus.start;
      end
      ST_RUN: begin
        w_run  = 1'b1;
        w_last = (r_idx == LAST_IDX);
      end
      default: begin
        w_accept = 1'b0;
      end
    endcase
  end

  // Operand capture, slice-by-slice addition and result/flag update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a     <= bus.a;
        r_b     <= w_b_in;
        r_carry <= bus.sub ? 1'b1 : bus.cin;
        r_res   <= '0;
        r_idx   <= '0;
        r_busy  <= 1'b1;
      end else if (w_run) begin
        r_a     <= r_a >> CHUNK;
        r_b     <= r_b >> CHUNK;
        r_res   <= w_full;
        r_carry <= w_slice[CHUNK];
        r_idx   <= r_idx + IDXW'(1);
        if (w_last) begin
          r_sum  <= w_full;
          r_cout <= w_slice[CHUNK];
          r_ovf  <= w_msb_cin ^ w_slice[CHUNK];
          r_zero <= (w_full == '0);
          r_neg  <= w_full[WIDTH-1];
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end else begin
          r_busy <= 1'b1;
        end
      end else begin
        r_busy <= r_busy;
      end
    end
  end

  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
  assign bus.zero = r_zero;
  assign bus.neg  = r_neg;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule
